hdlc_rx_frame_fifo: RTL and testbench

HDLC_RX_FRAME_FIFO -- requirements
Module: hdlc_rx_frame_fifo

---
 rtl/hdlc_rx_frame_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_hdlc_rx_frame_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_frame_fifo.sv
// hdlc_rx_frame_fifo: byte store for received HDLC frames; only committed (good) frames are visible to the reader.
// Latency: read data one cycle after Rx_RdBuff; a frame becomes visible the cycle after its Rx_EoF edge.
// Backpressure: none on the write side -- bytes with no space are dropped and flagged on Rx_Overflow; reads while empty are ignored.
module hdlc_rx_frame_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 128,
  parameter int MAX_FRAMES = 4,
  parameter int SIZE_W     = $clog2(DEPTH) + 1,
  parameter int CNT_W      = $clog2(MAX_FRAMES) + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx_WrBuff,
  input  logic [DATA_W-1:0] Rx_Data,
  input  logic              Rx_EoF,
  input  logic              Rx_FCSerr,
  input  logic              Rx_AbortSignal,
  input  logic              Rx_RdBuff,
  input  logic              Rx_Drop,
  output logic [DATA_W-1:0] Rx_DataBuffOut,
  output logic              Rx_Ready,
  output logic [SIZE_W-1:0] Rx_FrameSize,
  output logic              Rx_Overflow,
  output logic [CNT_W-1:0]  Rx_FrameCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(MAX_FRAMES);

  localparam logic [SIZE_W-1:0] DEPTH_V  = SIZE_W'(DEPTH);
  localparam logic [SIZE_W-1:0] SIZE_ONE = SIZE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [QW-1:0]     Q_ONE    = QW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_OVF  = 2'd2
  } wr_state_t;

  wr_state_t state;
  wr_state_t state_nxt;

  // Byte storage and pointers. Pointers carry one extra bit so full and empty differ.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [SIZE_W-1:0] wr_ptr;
  logic [SIZE_W-1:0] rd_ptr;
  logic [SIZE_W-1:0] commit_ptr;
  logic [SIZE_W-1:0] cur_len;
  logic [SIZE_W-1:0] head_done;

  // Committed frame lengths, oldest at sq_rd.
  logic [SIZE_W-1:0] size_q [MAX_FRAMES];
  logic [QW-1:0]     sq_wr;
  logic [QW-1:0]     sq_rd;
  logic [CNT_W-1:0]  frame_count;

  logic              overflow;
  logic [DATA_W-1:0] rd_data;

  // Write-side decode
  logic [SIZE_W-1:0] used;
  logic              space_ok;
  logic              wr_req;
  logic              eof;
  logic              slots_full;
  logic              accept;
  logic              full_drop;
  logic              commit;
  logic              discard;
  logic              slot_ovf;
  logic [SIZE_W-1:0] len_eff;

  // Read-side decode
  logic              ready;
  logic [SIZE_W-1:0] head_len;
  logic [SIZE_W-1:0] remaining;
  logic              drop;
  logic              rd;
  logic              pop;

  // Used space counts uncommitted bytes too, so a runaway frame cannot overwrite committed data.
  assign used       = wr_ptr - rd_ptr;
  assign space_ok   = (used != DEPTH_V);
  // Abort outranks everything else on the write side in the same cycle.
  assign wr_req     = Rx_WrBuff && !Rx_AbortSignal;
  assign eof        = Rx_EoF && !Rx_AbortSignal;
  assign slots_full = (frame_count == CNT_MAX);

  assign ready      = (frame_count != '0);
  assign head_len   = size_q[sq_rd];
  // Remaining bytes of the head frame; never lets the reader run past commit_ptr.
  assign remaining  = head_len - head_done;
  // Drop outranks a byte read in the same cycle.
  assign drop       = Rx_Drop && ready;
  assign rd         = Rx_RdBuff && ready && !drop;
  assign pop        = drop || (rd && (remaining == SIZE_ONE));

  // Write FSM state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Write FSM next-state: any frame end returns to IDLE, a full-buffer drop parks in OVF
  always_comb begin
    state_nxt = state;
    if (discard || commit)
      state_nxt = S_IDLE;
    else if (full_drop)
      state_nxt = S_OVF;
    else if (accept && (state == S_IDLE))
      state_nxt = S_RECV;
  end

  // Write FSM outputs: byte accept, commit/discard decisions for the in-progress frame
  always_comb begin
    accept    = 1'b0;
    full_drop = 1'b0;
    commit    = 1'b0;
    slot_ovf  = 1'b0;
    len_eff   = cur_len;
    case (state)
      S_IDLE, S_RECV: begin
        accept    = wr_req && space_ok;
        full_drop = wr_req && !space_ok;
        // A byte written together with EoF is the last byte of the frame.
        len_eff   = cur_len + SIZE_W'(accept);
        if (eof && !Rx_FCSerr && !full_drop && (len_eff != '0)) begin
          if (slots_full) slot_ovf = 1'b1;
          else            commit   = 1'b1;
        end
      end
      // Frame already lost: ignore bytes until EoF or abort rewinds it.
      S_OVF: ;
      default: ;
    endcase
    discard = Rx_AbortSignal || (eof && !commit);
  end

  // Byte storage write; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge Clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= Rx_Data;
  end

  // Write pointer, commit pointer and length of the frame being received
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      cur_len    <= '0;
    end else if (discard) begin
      wr_ptr  <= commit_ptr;
      cur_len <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + SIZE_ONE;
      if (commit) begin
        commit_ptr <= wr_ptr + SIZE_W'(accept);
        cur_len    <= '0;
      end else if (accept) begin
        cur_len <= cur_len + SIZE_ONE;
      end
    end
  end

  // Overflow flag: set when a frame loses space or a slot, cleared by the first byte of a new frame
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      overflow <= 1'b0;
    else if (full_drop || slot_ovf)
      overflow <= 1'b1;
    else if (accept && (state == S_IDLE))
      overflow <= 1'b0;
  end

  // Frame length queue and committed-frame count; commit and pop may coincide
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < MAX_FRAMES; i++) size_q[i] <= '0;
      sq_wr       <= '0;
      sq_rd       <= '0;
      frame_count <= '0;
    end else begin
      if (commit) begin
        size_q[sq_wr] <= len_eff;
        sq_wr         <= sq_wr + Q_ONE;
      end
      if (pop) sq_rd <= sq_rd + Q_ONE;
      case ({commit, pop})
        2'b10:   frame_count <= frame_count + CNT_ONE;
        2'b01:   frame_count <= frame_count - CNT_ONE;
        default: frame_count <= frame_count;
      endcase
    end
  end

  // Read pointer, head progress and registered read data
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_ptr    <= '0;
      head_done <= '0;
      rd_data   <= '0;
    end else begin
      if (drop)    rd_ptr <= rd_ptr + remaining;
      else if (rd) rd_ptr <= rd_ptr + SIZE_ONE;
      if (pop)     head_done <= '0;
      else if (rd) head_done <= head_done + SIZE_ONE;
      if (rd)      rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  assign Rx_DataBuffOut = rd_data;
  assign Rx_Ready       = ready;
  assign Rx_FrameSize   = ready ? head_len : '0;
  assign Rx_Overflow    = overflow;
  assign Rx_FrameCount  = frame_count;

endmodule

// File: tb/tb_hdlc_rx_frame_fifo.sv
// Directed bench for hdlc_rx_frame_fifo with a byte/frame scoreboard.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Small geometry (DEPTH=16, MAX_FRAMES=4) so full-buffer and slot limits are reachable.
module tb_hdlc_rx_frame_fifo;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 16;
  localparam int MAX_FRAMES = 4;
  localparam int SIZE_W     = $clog2(DEPTH) + 1;
  localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              Rx_WrBuff;
  logic [DATA_W-1:0] Rx_Data;
  logic              Rx_EoF;
  logic              Rx_FCSerr;
  logic              Rx_AbortSignal;
  logic              Rx_RdBuff;
  logic              Rx_Drop;
  logic [DATA_W-1:0] Rx_DataBuffOut;
  logic              Rx_Ready;
  logic [SIZE_W-1:0] Rx_FrameSize;
  logic              Rx_Overflow;
  logic [CNT_W-1:0]  Rx_FrameCount;

  int tests = 0;
  int fails = 0;

  // Scoreboard: committed bytes in read order, committed frame lengths, bytes consumed of head.
  logic [7:0] sb[$];
  int         fl_q[$];
  int         consumed = 0;

  always #5 Clk = ~Clk;

  hdlc_rx_frame_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_FRAMES(MAX_FRAMES)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .Rx_WrBuff(Rx_WrBuff), .Rx_Data(Rx_Data), .Rx_EoF(Rx_EoF), .Rx_FCSerr(Rx_FCSerr),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_RdBuff(Rx_RdBuff), .Rx_Drop(Rx_Drop),
    .Rx_DataBuffOut(Rx_DataBuffOut), .Rx_Ready(Rx_Ready), .Rx_FrameSize(Rx_FrameSize),
    .Rx_Overflow(Rx_Overflow), .Rx_FrameCount(Rx_FrameCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rx_WrBuff = 1'b0; Rx_Data = '0; Rx_EoF = 1'b0; Rx_FCSerr = 1'b0;
    Rx_AbortSignal = 1'b0; Rx_RdBuff = 1'b0; Rx_Drop = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic with_eof, input logic fcs);
    Rx_WrBuff = 1'b1; Rx_Data = d; Rx_EoF = with_eof; Rx_FCSerr = fcs;
    cycle();
    clear_inputs();
  endtask

  task automatic pulse_eof(input logic fcs);
    Rx_EoF = 1'b1; Rx_FCSerr = fcs;
    cycle();
    clear_inputs();
  endtask

  // Expected head-frame status derived from the scoreboard.
  task automatic check_status(input string tag);
    check({tag, "_ready"}, 32'(Rx_Ready), 32'(fl_q.size() != 0));
    check({tag, "_size"},  32'(Rx_FrameSize), 32'((fl_q.size() != 0) ? fl_q[0] : 0));
    check({tag, "_count"}, 32'(Rx_FrameCount), 32'(fl_q.size()));
  endtask

  task automatic model_consume_one(output logic [7:0] exp);
    exp = sb.pop_front();
    consumed++;
    if (consumed == fl_q[0]) begin
      void'(fl_q.pop_front());
      consumed = 0;
    end
  endtask

  task automatic read_one(input string tag);
    logic [7:0] exp;
    Rx_RdBuff = 1'b1;
    cycle();
    Rx_RdBuff = 1'b0;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, Rx_DataBuffOut);
    end else begin
      model_consume_one(exp);
      check(tag, 32'(Rx_DataBuffOut), 32'(exp));
    end
  endtask

  task automatic drop_head();
    Rx_Drop = 1'b1;
    cycle();
    Rx_Drop = 1'b0;
    repeat (fl_q[0] - consumed) void'(sb.pop_front());
    void'(fl_q.pop_front());
    consumed = 0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!Rx_Ready && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(Rx_Ready), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(Rx_DataBuffOut), 32'(0));
    check({tag, "_ready"}, 32'(Rx_Ready), 32'(0));
    check({tag, "_size"},  32'(Rx_FrameSize), 32'(0));
    check({tag, "_ovf"},   32'(Rx_Overflow), 32'(0));
    check({tag, "_count"}, 32'(Rx_FrameCount), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp;
    clear_inputs();
    Rst = 1'b1;

    // Reset state
    repeat (3) cycle();
    check_all_zero("reset");
    Rst = 1'b0;
    cycle();

    // Basic 3-byte frame, then read with nothing held
    write_byte(8'h11, 1'b0, 1'b0);
    write_byte(8'h22, 1'b0, 1'b0);
    write_byte(8'h33, 1'b0, 1'b0);
    pulse_eof(1'b0);
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33); fl_q.push_back(3);
    wait_ready("basic_ready", 4);
    check_status("basic");
    read_one("basic_rd0");
    read_one("basic_rd1");
    read_one("basic_rd2");
    check_status("basic_empty");
    Rx_RdBuff = 1'b1;
    cycle();
    Rx_RdBuff = 1'b0;
    check("empty_rd_hold", 32'(Rx_DataBuffOut), 32'h33);

    // Bad FCS frame is discarded; next good frame ends with byte+EoF together
    for (int i = 0; i < 5; i++) write_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
    pulse_eof(1'b1);
    check_status("fcs_bad");
    write_byte(8'hB1, 1'b0, 1'b0);
    write_byte(8'hB2, 1'b1, 1'b0);
    sb.push_back(8'hB1); sb.push_back(8'hB2); fl_q.push_back(2);
    check_status("fcs_good");
    read_one("fcs_rd0");
    read_one("fcs_rd1");

    // Buffer overflow with an earlier committed frame held
    write_byte(8'hC1, 1'b0, 1'b0);
    write_byte(8'hC2, 1'b0, 1'b0);
    pulse_eof(1'b0);
    sb.push_back(8'hC1); sb.push_back(8'hC2); fl_q.push_back(2);
    for (int i = 0; i < DEPTH - 2; i++) write_byte(8'hD0 + 8'(i), 1'b0, 1'b0);
    check("full_no_ovf", 32'(Rx_Overflow), 32'(0));
    write_byte(8'hEE, 1'b0, 1'b0);
    check("full_ovf_set", 32'(Rx_Overflow), 32'(1));
    pulse_eof(1'b0);
    check("full_ovf_hold", 32'(Rx_Overflow), 32'(1));
    check_status("full_after_eof");
    write_byte(8'hF1, 1'b0, 1'b0);
    check("ovf_clear", 32'(Rx_Overflow), 32'(0));
    pulse_eof(1'b0);
    sb.push_back(8'hF1); fl_q.push_back(1);
    check_status("full_recover");
    read_one("full_rd0");
    read_one("full_rd1");
    read_one("full_rd2");
    check_status("full_empty");

    // Frame slot limit
    for (int i = 0; i < MAX_FRAMES; i++) begin
      write_byte(8'h40 + 8'(i), 1'b1, 1'b0);
      sb.push_back(8'h40 + 8'(i)); fl_q.push_back(1);
    end
    check_status("slots_full");
    write_byte(8'h4F, 1'b0, 1'b0);
    pulse_eof(1'b0);
    check("slot_ovf", 32'(Rx_Overflow), 32'(1));
    check_status("slot_after_eof");
    drop_head();
    check_status("slot_drop");
    read_one("slot_rd0");
    read_one("slot_rd1");
    read_one("slot_rd2");
    check_status("slot_empty");

    // Partial read then drop; commit coinciding with the final read of the head
    for (int i = 0; i < 4; i++) write_byte(8'h50 + 8'(i), 1'b0, 1'b0);
    pulse_eof(1'b0);
    for (int i = 0; i < 4; i++) sb.push_back(8'h50 + 8'(i));
    fl_q.push_back(4);
    write_byte(8'h60, 1'b0, 1'b0);
    write_byte(8'h61, 1'b0, 1'b0);
    pulse_eof(1'b0);
    sb.push_back(8'h60); sb.push_back(8'h61); fl_q.push_back(2);
    check_status("drop_two");
    read_one("drop_rd0");
    drop_head();
    check_status("drop_after");
    read_one("drop_rd1");
    write_byte(8'h70, 1'b0, 1'b0);
    Rx_EoF = 1'b1; Rx_RdBuff = 1'b1;
    cycle();
    clear_inputs();
    model_consume_one(exp);
    check("same_cycle_data", 32'(Rx_DataBuffOut), 32'(exp));
    sb.push_back(8'h70); fl_q.push_back(1);
    check_status("same_cycle");
    read_one("same_cycle_rd");

    // Abort (with simultaneous byte+EoF), then reset in the middle of a read
    write_byte(8'h80, 1'b0, 1'b0);
    write_byte(8'h81, 1'b0, 1'b0);
    Rx_AbortSignal = 1'b1; Rx_WrBuff = 1'b1; Rx_Data = 8'h82; Rx_EoF = 1'b1;
    cycle();
    clear_inputs();
    check_status("abort");
    for (int i = 0; i < 3; i++) write_byte(8'h90 + 8'(i), 1'b0, 1'b0);
    pulse_eof(1'b0);
    for (int i = 0; i < 3; i++) sb.push_back(8'h90 + 8'(i));
    fl_q.push_back(3);
    read_one("abort_rd0");
    Rx_RdBuff = 1'b1;
    Rst = 1'b1;
    cycle();
    check_all_zero("midread_rst");
    Rst = 1'b0;
    clear_inputs();
    sb.delete(); fl_q.delete(); consumed = 0;
    repeat (3) cycle();
    check_all_zero("post_rst");
    write_byte(8'hA5, 1'b1, 1'b0);
    sb.push_back(8'hA5); fl_q.push_back(1);
    check_status("post_rst_frame");
    read_one("post_rst_rd");
    check_status("post_rst_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
